// File: rtl/alu_pkg.sv
// Shared opcode map, widths and FSM state encoding for alu and alu_arb.
package alu_pkg;
    localparam int OP_W               = 6;
    localparam int DATA_WIDTH_DEFAULT = 32;

    localparam logic [OP_W-1:0] OP_ALU_ADD = 6'h00;
    localparam logic [OP_W-1:0] OP_ALU_SUB = 6'h01;
    localparam logic [OP_W-1:0] OP_ALU_AND = 6'h02;
    localparam logic [OP_W-1:0] OP_ALU_OR  = 6'h03;
    localparam logic [OP_W-1:0] OP_ALU_XOR = 6'h04;
    localparam logic [OP_W-1:0] OP_ALU_SLL = 6'h05;
    localparam logic [OP_W-1:0] OP_ALU_SRL = 6'h06;
    localparam logic [OP_W-1:0] OP_ALU_SRA = 6'h07;
    localparam logic [OP_W-1:0] OP_ALU_SLT = 6'h08;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;
endpackage

// File: rtl/alu.sv
// Combinational ALU; unknown opcodes produce zero.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic [OP_W-1:0]       op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);
    localparam int SH_W = $clog2(DATA_WIDTH);

    logic signed [DATA_WIDTH-1:0] a_s;
    logic signed [DATA_WIDTH-1:0] b_s;
    logic        [SH_W-1:0]       sh;

    assign a_s = a;
    assign b_s = b;
    assign sh  = b[SH_W-1:0];

    always_comb begin
        y = '0;
        case (op)
            OP_ALU_ADD: y = a + b;
            OP_ALU_SUB: y = a - b;
            OP_ALU_AND: y = a & b;
            OP_ALU_OR:  y = a | b;
            OP_ALU_XOR: y = a ^ b;
            OP_ALU_SLL: y = a << sh;
            OP_ALU_SRL: y = a >> sh;
            OP_ALU_SRA: y = a_s >>> sh;
            OP_ALU_SLT: y = {{(DATA_WIDTH-1){1'b0}}, (a_s < b_s)};
            default:    y = '0;
        endcase
    end
endmodule

// File: rtl/alu_arb.sv
// Two-requester front end sharing one alu, one transaction at a time.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arb
    import alu_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ*OP_W-1:0]       i_req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_b,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    output logic [DATA_WIDTH-1:0]         o_rsp_data,
    input  logic [NUM_REQ-1:0]            i_rsp_ready
);
    arb_state_e            state;
    logic                  grant_q;
    logic                  win;
    logic                  any_valid;
    logic [OP_W-1:0]       op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] alu_y;

    assign any_valid = |i_req_valid;

`ifdef ALU_ARB_RR_EN
    logic ptr_q;

    // Contention goes to the pointer holder; a lone request always wins.
    always_comb begin
        win = ~i_req_valid[0];
        if (&i_req_valid) win = ptr_q;
    end
`else
    always_comb begin
        win = ~i_req_valid[0];
    end
`endif

    always_comb begin
        o_req_ready = '0;
        if (!i_rst && state == ST_IDLE && any_valid) o_req_ready[win] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            grant_q     <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
`ifdef ALU_ARB_RR_EN
            ptr_q       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        grant_q <= win;
                        op_q    <= win ? i_req_op[2*OP_W-1:OP_W] : i_req_op[OP_W-1:0];
                        a_q     <= win ? i_req_a[2*DATA_WIDTH-1:DATA_WIDTH] : i_req_a[DATA_WIDTH-1:0];
                        b_q     <= win ? i_req_b[2*DATA_WIDTH-1:DATA_WIDTH] : i_req_b[DATA_WIDTH-1:0];
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    o_rsp_data           <= alu_y;
                    o_rsp_valid          <= '0;
                    o_rsp_valid[grant_q] <= 1'b1;
                    state                <= ST_RESP;
                end
                ST_RESP: begin
                    // Only the owning requester's ready can retire the response.
                    if (i_rsp_ready[grant_q]) begin
                        o_rsp_valid <= '0;
                        state       <= ST_IDLE;
`ifdef ALU_ARB_RR_EN
                        ptr_q       <= ~grant_q;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .op(op_q),
        .a (a_q),
        .b (b_q),
        .y (alu_y)
    );
endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb; expectations follow ALU_ARB_RR_EN when defined.
module tb_alu_arb;
    import alu_pkg::*;

    localparam int DW = 32;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [1:0]    i_req_valid = '0;
    logic [1:0]    o_req_ready;
    logic [11:0]   i_req_op = '0;
    logic [2*DW-1:0] i_req_a = '0;
    logic [2*DW-1:0] i_req_b = '0;
    logic [1:0]    o_rsp_valid;
    logic [DW-1:0] o_rsp_data;
    logic [1:0]    i_rsp_ready = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    alu_arb #(.NUM_REQ(2), .DATA_WIDTH(DW)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_req_op   (i_req_op),
        .i_req_a    (i_req_a),
        .i_req_b    (i_req_b),
        .o_rsp_valid(o_rsp_valid),
        .o_rsp_data (o_rsp_data),
        .i_rsp_ready(i_rsp_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [5:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (r == 0) begin
            i_req_op[5:0]   = op;
            i_req_a[DW-1:0] = a;
            i_req_b[DW-1:0] = b;
        end else begin
            i_req_op[11:6]     = op;
            i_req_a[2*DW-1:DW] = a;
            i_req_b[2*DW-1:DW] = b;
        end
    endtask

    task automatic do_reset();
        i_rst       = 1'b1;
        i_req_valid = 2'b00;
        i_rsp_ready = 2'b00;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    // Full handshake with inputs already set and the arbiter idle; g is the expected winner.
    task automatic txn(input string tag, input int g, input logic [DW-1:0] exp);
        logic [1:0] oh;
        oh = (g == 0) ? 2'b01 : 2'b10;
        #1;
        chk({tag, "_ready"}, o_req_ready, oh);
        tick();
        chk({tag, "_exec_ready"}, o_req_ready, 2'b00);
        chk({tag, "_exec_vld"}, o_rsp_valid, 2'b00);
        tick();
        chk({tag, "_vld"}, o_rsp_valid, oh);
        chk({tag, "_data"}, o_rsp_data, exp);
        i_rsp_ready = oh;
        tick();
        chk({tag, "_done"}, o_rsp_valid, 2'b00);
        i_rsp_ready = 2'b00;
    endtask

    initial begin
        // Reset with both requests raised: nothing may be granted.
        i_rst       = 1'b1;
        i_req_valid = 2'b11;
        tick();
        tick();
        chk("rst_ready", o_req_ready, 2'b00);
        chk("rst_vld", o_rsp_valid, 2'b00);
        chk("rst_data", o_rsp_data, 0);
        i_req_valid = 2'b00;
        i_rst = 1'b0;
        tick();
        chk("idle_ready", o_req_ready, 2'b00);

        // Single add.
        set_req(0, OP_ALU_ADD, 32'd5, 32'd7);
        i_req_valid = 2'b01;
        #1;
        chk("add_ready", o_req_ready, 2'b01);
        tick();
        i_req_valid = 2'b00;
        #1;
        chk("add_exec_ready", o_req_ready, 2'b00);
        chk("add_exec_vld", o_rsp_valid, 2'b00);
        tick();
        chk("add_vld", o_rsp_valid, 2'b01);
        chk("add_data", o_rsp_data, 32'd12);
        i_rsp_ready = 2'b01;
        tick();
        chk("add_done", o_rsp_valid, 2'b00);
        i_rsp_ready = 2'b00;

        // Contention from a fresh pointer.
        do_reset();
        set_req(0, OP_ALU_SUB, 32'd10, 32'd3);
        set_req(1, OP_ALU_SRA, 32'h8000_0000, 32'd4);
        i_req_valid = 2'b11;
`ifdef ALU_ARB_RR_EN
        txn("rr0", 0, 32'd7);
        txn("rr1", 1, 32'hF800_0000);
`else
        txn("fp0", 0, 32'd7);
        txn("fp1", 0, 32'd7);
        txn("fp2", 0, 32'd7);
`endif
        i_req_valid = 2'b00;

        // Backpressure: response held, new requests refused, foreign ready ignored.
        set_req(0, OP_ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
        i_req_valid = 2'b01;
        #1;
        chk("bp_ready", o_req_ready, 2'b01);
        tick();
        i_req_valid = 2'b00;
        tick();
        i_req_valid = 2'b11;
        i_rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold_vld", o_rsp_valid, 2'b01);
            chk("bp_hold_data", o_rsp_data, 32'h0000_F000);
            chk("bp_hold_ready", o_req_ready, 2'b00);
            tick();
        end
        i_rsp_ready = 2'b01;
        tick();
        i_req_valid = 2'b00;
        i_rsp_ready = 2'b00;
        chk("bp_done", o_rsp_valid, 2'b00);

        // Operands change after acceptance.
        set_req(0, OP_ALU_ADD, 32'd1, 32'd1);
        i_req_valid = 2'b01;
        #1;
        chk("chg_ready", o_req_ready, 2'b01);
        tick();
        set_req(0, OP_ALU_ADD, 32'd100, 32'd100);
        i_req_valid = 2'b00;
        tick();
        chk("chg_vld", o_rsp_valid, 2'b01);
        chk("chg_data", o_rsp_data, 32'd2);
        i_rsp_ready = 2'b01;
        tick();
        i_rsp_ready = 2'b00;

        // Reset while a response is pending.
        set_req(1, OP_ALU_XOR, 32'h0000_00FF, 32'h0000_000F);
        i_req_valid = 2'b10;
        #1;
        chk("rr_ready", o_req_ready, 2'b10);
        tick();
        i_req_valid = 2'b00;
        tick();
        chk("rr_vld", o_rsp_valid, 2'b10);
        chk("rr_data", o_rsp_data, 32'h0000_00F0);
        i_rst = 1'b1;
        tick();
        chk("rr_rst_vld", o_rsp_valid, 2'b00);
        chk("rr_rst_data", o_rsp_data, 0);
        chk("rr_rst_ready", o_req_ready, 2'b00);
        i_rst = 1'b0;
        set_req(0, OP_ALU_ADD, 32'd2, 32'd3);
        set_req(1, OP_ALU_ADD, 32'd4, 32'd4);
        i_req_valid = 2'b11;
        txn("post_rst", 0, 32'd5);
        i_req_valid = 2'b00;

        // Unsupported opcode.
        set_req(0, 6'h3F, 32'd123, 32'd456);
        i_req_valid = 2'b01;
        txn("bad_op", 0, 32'd0);
        i_req_valid = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
